md5_msg_padder: RTL and testbench

Message front end for the MD5 datapath. It accepts a byte stream and builds 512-bit blocks padded per RFC 1321: an 0x80 marker, zero fill, and a 64-bit little-endian bit length. Each block is presented to the hash core as sixteen 32-bit words over a valid/ready handshake, with a flag that marks the final block of the message. It sits between the host byte interface and the round-computation core.

---
 rtl/md5_msg_padder.sv | 103 ++++++++++
 tb/tb_md5_msg_padder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_msg_padder.sv
// rtl/md5_msg_padder.sv - RFC 1321 message padder feeding 512-bit blocks to the MD5 core
// Bytes fill a 64-byte buffer; the 0x80 marker and length are written in place, and zero fill comes from clearing on handoff.
module md5_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_last_i,
  input  logic        in_empty_i,
  output logic        in_ready_o,
  output logic [31:0] blk_o [0:15],
  output logic        blk_valid_o,
  input  logic        blk_ready_i,
  output logic        blk_last_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {FILL, PAD, LEN, EMIT} state_t;

  state_t           state;
  state_t           ret_state;
  logic             final_blk;
  logic [7:0]       msg_buf [0:63];
  logic [5:0]       ptr;
  logic [LEN_W-1:0] bitlen;
  logic [63:0]      len64;

  assign len64 = 64'(bitlen);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= FILL;
      ret_state <= FILL;
      final_blk <= 1'b0;
      ptr       <= 6'd0;
      bitlen    <= '0;
      for (int i = 0; i < 64; i++) msg_buf[i] <= 8'h00;
    end else begin
      case (state)
        FILL: begin
          if (in_valid_i && !in_empty_i) begin
            msg_buf[ptr] <= in_data_i;
            ptr          <= ptr + 6'd1;
            bitlen       <= bitlen + LEN_W'(8);
            // A full buffer goes out before the marker; PAD resumes at ptr 0 if this was the last byte.
            if (ptr == 6'd63) begin
              state     <= EMIT;
              final_blk <= 1'b0;
              ret_state <= in_last_i ? PAD : FILL;
            end else if (in_last_i) begin
              state <= PAD;
            end
          end else if (in_valid_i && in_last_i) begin
            state <= PAD;
          end
        end
        PAD: begin
          msg_buf[ptr] <= 8'h80;
          ptr          <= ptr + 6'd1;
          if (ptr <= 6'd55) begin
            state <= LEN;
          end else begin
            state     <= EMIT;
            final_blk <= 1'b0;
            ret_state <= LEN;
          end
        end
        LEN: begin
          for (int k = 0; k < 8; k++) msg_buf[56 + k] <= len64[8*k +: 8];
          state     <= EMIT;
          final_blk <= 1'b1;
          ret_state <= FILL;
        end
        EMIT: begin
          if (blk_ready_i) begin
            for (int i = 0; i < 64; i++) msg_buf[i] <= 8'h00;
            ptr   <= 6'd0;
            state <= ret_state;
            if (final_blk) bitlen <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Outputs are forced quiet during reset so a discarded block is never visible.
  assign in_ready_o  = !rst_i && (state == FILL);
  assign blk_valid_o = !rst_i && (state == EMIT);
  assign blk_last_o  = !rst_i && (state == EMIT) && final_blk;
  assign busy_o      = !rst_i && ((state != FILL) || (ptr != 6'd0));

  always_comb begin
    for (int j = 0; j < 16; j++) begin
      blk_o[j] = 32'h0;
      if (!rst_i)
        blk_o[j] = {msg_buf[4*j+3], msg_buf[4*j+2], msg_buf[4*j+1], msg_buf[4*j]};
    end
  end

endmodule

// File: tb/tb_md5_msg_padder.sv
// tb/tb_md5_msg_padder.sv - randomized bench for md5_msg_padder against an RFC 1321 padding model
module tb_md5_msg_padder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_empty = 1'b0;
  logic        in_ready;
  logic [31:0] blk [0:15];
  logic        blk_valid;
  logic        blk_ready = 1'b0;
  logic        blk_last;
  logic        busy;

  md5_msg_padder #(.LEN_W(64)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_last_i(in_last), .in_empty_i(in_empty), .in_ready_o(in_ready),
    .blk_o(blk), .blk_valid_o(blk_valid), .blk_ready_i(blk_ready),
    .blk_last_o(blk_last), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [7:0]  msg [$];
  logic [31:0] rx_words [$];
  logic        rx_last [$];
  int          accept_cyc = 0;
  bit          accept_done = 0;
  int          lat_cyc = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rxw(input int b, input int j);
    if (16*b + j < rx_words.size()) return rx_words[16*b + j];
    return 32'hDEADBEEF;
  endfunction

  function automatic logic rxl(input int b);
    if (b < rx_last.size()) return rx_last[b];
    return 1'bx;
  endfunction

  task automatic drive_beat(input logic [7:0] d, input logic l, input logic e);
    bit rdy = 0;
    int budget = 0;
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d; in_last = l; in_empty = e;
    while (!rdy && budget < 3000) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1; budget++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    if (!rdy) check("send_timeout", 0, 1);
    accept_cyc = cyc;
  endtask

  // kind: 0 = no terminating beat, 1 = last on final byte, 2 = trailing empty last beat
  task automatic send_msg(input int kind, input bit errs);
    int nb = msg.size();
    int total = nb + ((kind == 2) ? 1 : 0);
    for (int i = 0; i < total; i++) begin
      if (errs && $urandom_range(0, 7) == 0) drive_beat(8'($urandom), 1'b0, 1'b1);
      if (i < nb) drive_beat(msg[i], (kind == 1) && (i == nb - 1), 1'b0);
      else        drive_beat(8'($urandom), 1'b1, 1'b1);
    end
    if (kind != 0) accept_done = 1;
  endtask

  // mode: 0 = always ready, 1 = random ready, 2 = stall the first block for 5 cycles
  task automatic recv_blocks(input int mode);
    logic [31:0] snap [0:15];
    logic        snap_last = 1'b0;
    bit          in_blk = 0;
    bit          done = 0;
    bit          same;
    int          hold = 0;
    int          budget = 0;
    while (!done && budget < 4000) begin
      @(negedge clk); budget++;
      if (blk_valid) begin
        if (!in_blk && accept_done && lat_cyc < 0) lat_cyc = cyc;
        if (in_blk) begin
          same = 1;
          for (int j = 0; j < 16; j++) if (blk[j] !== snap[j]) same = 0;
          if (blk_last !== snap_last) same = 0;
          check("hold_stable", 64'(same), 1);
        end
        for (int j = 0; j < 16; j++) snap[j] = blk[j];
        snap_last = blk_last;
        in_blk = 1;
        case (mode)
          0:       blk_ready = 1'b1;
          1:       blk_ready = 1'($urandom_range(0, 1));
          default: blk_ready = (hold >= 5);
        endcase
        hold++;
        if (blk_ready) begin
          for (int j = 0; j < 16; j++) rx_words.push_back(blk[j]);
          rx_last.push_back(blk_last);
          in_blk = 0;
          if (blk_last) done = 1;
        end
      end else begin
        if (in_blk) check("valid_held", 0, 1);
        in_blk = 0;
        blk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    if (!done) check("recv_timeout", 0, 1);
  endtask

  task automatic run_msg(input int kind, input int mode, input bit errs);
    logic [7:0]  e [$];
    logic [63:0] bits;
    logic [31:0] w;
    int nblk, expl, n;
    rx_words.delete(); rx_last.delete();
    accept_done = 0; lat_cyc = -1;
    n = msg.size();
    e = msg;
    e.push_back(8'h80);
    while (e.size() % 64 != 56) e.push_back(8'h00);
    bits = 64'(n) * 64'd8;
    for (int k = 0; k < 8; k++) e.push_back(bits[8*k +: 8]);
    nblk = e.size() / 64;
    if (kind == 1 && n % 64 == 0) expl = 1;
    else expl = (n % 64 <= 55) ? 3 : 2;
    fork
      send_msg(kind, errs);
      recv_blocks(mode);
    join
    @(posedge clk); #1; blk_ready = 1'b0;
    check("latency", 64'(lat_cyc - accept_cyc + 1), 64'(expl));
    check("nblk", 64'(rx_last.size()), 64'(nblk));
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 16; j++) begin
        w = {e[64*b+4*j+3], e[64*b+4*j+2], e[64*b+4*j+1], e[64*b+4*j]};
        check($sformatf("blk%0d_w%0d len%0d", b, j, n), rxw(b, j), w);
      end
      check($sformatf("last%0d len%0d", b, n), rxl(b), 64'(b == nblk - 1));
    end
    repeat (3) @(negedge clk);
    check("idle_valid", blk_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_blk_w0", blk[0], 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", blk_valid, 0);
    @(posedge clk); #1;
  endtask

  int len_tab [12] = '{54, 55, 56, 57, 62, 63, 64, 65, 119, 120, 127, 128};

  initial begin
    int n, kind, wait_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_blk_valid", blk_valid, 0);
    check("reset_blk_last", blk_last, 0);
    check("reset_busy", busy, 0);
    check("reset_blk_w0", blk[0], 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("first_ready", in_ready, 1);
    @(posedge clk); #1;

    msg.delete();
    run_msg(2, 0, 0);
    check("empty_w0", rxw(0, 0), 32'h00000080);

    msg = {8'h61, 8'h62, 8'h63};
    run_msg(1, 0, 0);
    check("abc_w0", rxw(0, 0), 32'h80636261);
    check("abc_w14", rxw(0, 14), 32'h00000018);

    msg.delete();
    repeat (55) msg.push_back(8'h41);
    run_msg(1, 0, 0);
    check("b55_w13", rxw(0, 13), 32'h80414141);
    check("b55_w14", rxw(0, 14), 32'h000001B8);

    msg.push_back(8'h41);
    run_msg(1, 2, 0);
    check("b56_w14", rxw(0, 14), 32'h00000080);
    check("b56_w15", rxw(0, 15), 32'h00000000);
    check("b56_final_w14", rxw(1, 14), 32'h000001C0);

    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'(i));
    run_msg(1, 1, 0);
    check("b64_w0", rxw(0, 0), 32'h03020100);
    check("b64_final_w0", rxw(1, 0), 32'h00000080);
    check("b64_final_w14", rxw(1, 14), 32'h00000200);

    msg.delete();
    repeat (10) msg.push_back(8'h5A);
    send_msg(0, 0);
    pulse_reset();
    msg = {8'h61, 8'h62, 8'h63};
    run_msg(1, 0, 0);
    check("rst_abc_w0", rxw(0, 0), 32'h80636261);

    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    send_msg(0, 0);
    wait_cnt = 0;
    do begin @(negedge clk); wait_cnt++; end while (!blk_valid && wait_cnt < 10);
    check("emit_before_rst", blk_valid, 1);
    pulse_reset();
    msg = {8'h61, 8'h62, 8'h63};
    run_msg(1, 1, 0);
    check("emit_rst_abc_w0", rxw(0, 0), 32'h80636261);

    for (int t = 0; t < 24; t++) begin
      msg.delete();
      n = (t < 12) ? len_tab[t] : $urandom_range(0, 140);
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      kind = (n == 0) ? 2 : $urandom_range(1, 2);
      run_msg(kind, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
